// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IADD word-pair reassembly, registered decoded fields.
// Optional FETCH_HLT_EN macro enables HLT detection and the HALTED state.
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [6:0]      opcode,
    output logic [2:0]      rsrc,
    output logic [2:0]      rdst,
    output logic [15:0]     imm,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc_out,
    output logic            halted
);

    localparam logic [6:0] OP_NOP  = 7'b1101000;
    localparam logic [6:0] OP_IADD = 7'b0100000;
`ifdef FETCH_HLT_EN
    localparam logic [6:0] OP_HLT  = 7'b1100001;
`endif
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        FETCH_IMM = 2'd1
`ifdef FETCH_HLT_EN
        , HALTED  = 2'd2
`endif
    } state_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic        valid;
    } instr_t;

    localparam instr_t BUBBLE = '{op: OP_NOP, rs: 3'd0, rd: 3'd0, imm: 16'd0, valid: 1'b0};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic [PC_W-1:0] hold_pc_q, hold_pc_d;
    logic [2:0]      hold_rs_q, hold_rs_d;
    logic [2:0]      hold_rd_q, hold_rd_d;
    instr_t          out_q, out_d;

    logic [6:0] word_op;
    logic [2:0] word_rs;
    logic [2:0] word_rd;
    logic       unused_low_bits;

    assign word_op = imem_data[15:9];
    assign word_rs = imem_data[8:6];
    assign word_rd = imem_data[5:3];
    // Bits [2:0] of an instruction word carry no field.
    assign unused_low_bits = ^imem_data[2:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_out_d  = pc_out_q;
        hold_pc_d = hold_pc_q;
        hold_rs_d = hold_rs_q;
        hold_rd_d = hold_rd_q;
        out_d     = out_q;

`ifdef FETCH_HLT_EN
        if (state_q == HALTED) begin
            out_d = BUBBLE;
        end else
`endif
        if (branch_taken) begin
            // Redirect abandons any half-assembled IADD.
            pc_d    = branch_target;
            out_d   = BUBBLE;
            state_d = FETCH;
        end else if (!stall) begin
            case (state_q)
                FETCH: begin
                    if (word_op == OP_IADD) begin
                        hold_pc_d = pc_q;
                        hold_rs_d = word_rs;
                        hold_rd_d = word_rd;
                        out_d     = BUBBLE;
                        pc_d      = pc_q + PC_ONE;
                        state_d   = FETCH_IMM;
`ifdef FETCH_HLT_EN
                    end else if (word_op == OP_HLT) begin
                        out_d    = '{op: word_op, rs: word_rs, rd: word_rd, imm: 16'd0, valid: 1'b1};
                        pc_out_d = pc_q;
                        state_d  = HALTED;
`endif
                    end else begin
                        out_d    = '{op: word_op, rs: word_rs, rd: word_rd, imm: 16'd0, valid: 1'b1};
                        pc_out_d = pc_q;
                        pc_d     = pc_q + PC_ONE;
                    end
                end
                FETCH_IMM: begin
                    out_d    = '{op: OP_IADD, rs: hold_rs_q, rd: hold_rd_q, imm: imem_data, valid: 1'b1};
                    pc_out_d = hold_pc_q;
                    pc_d     = pc_q + PC_ONE;
                    state_d  = FETCH;
                end
                default: begin
                    out_d   = BUBBLE;
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pc_out_q  <= RESET_PC;
            hold_pc_q <= RESET_PC;
            hold_rs_q <= 3'd0;
            hold_rd_q <= 3'd0;
            out_q     <= BUBBLE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_out_q  <= pc_out_d;
            hold_pc_q <= hold_pc_d;
            hold_rs_q <= hold_rs_d;
            hold_rd_q <= hold_rd_d;
            out_q     <= out_d;
        end
    end

    assign imem_addr   = pc_q;
    assign opcode      = out_q.op;
    assign rsrc        = out_q.rs;
    assign rdst        = out_q.rd;
    assign imm         = out_q.imm;
    assign instr_valid = out_q.valid;
    assign pc_out      = pc_out_q;

`ifdef FETCH_HLT_EN
    assign halted = (state_q == HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage feeding the control unit's 7-bit opcode input. It holds the program counter, reads 16-bit words from instruction memory, and reassembles two-word instructions (IADD plus its immediate). It presents one registered, decoded-field instruction per cycle to the decode/control stage, with stall, branch redirect and halt handling.

## Interface
- PC_W, 16, program counter and instruction-memory address width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- stall  input  1  hold PC, state and all outputs this cycle
- branch_taken  input  1  redirect fetch to branch_target
- branch_target  input  PC_W  redirect address
- imem_addr  output  PC_W  instruction memory read address (= PC, combinational from PC register)
- imem_data  input  16  word at imem_addr, valid in the same cycle (asynchronous read)
- opcode  output  7  registered instruction bits [15:9]; drives control unit opcode
- rsrc  output  3  registered bits [8:6]
- rdst  output  3  registered bits [5:3]
- imm  output  16  immediate of a two-word instruction; 0 otherwise
- instr_valid  output  1  outputs carry a real instruction
- pc_out  output  PC_W  address of first word of the presented instruction
- halted  output  1  fetch stopped on HLT

## Operation
- Word format: [15:9] opcode, [8:6] rsrc, [5:3] rdst, [2:0] ignored.
- Two-word opcode: 7'b0100000 (IADD); all others one word.
- Bubble rule: whenever instr_valid=0, opcode=7'b1101000 (NOP), rsrc=rdst=0, imm=0.
- States: FETCH, FETCH_IMM, HALTED.
- FETCH, one-word opcode: register fields, pc_out<=PC, instr_valid<=1, PC<=PC+1, stay FETCH.
- FETCH, IADD: save fields and PC into hold registers, emit bubble, PC<=PC+1, go FETCH_IMM.
- FETCH_IMM: imm<=imem_data, present held fields, pc_out<=held PC, instr_valid<=1, PC<=PC+1, go FETCH.
- FETCH, HLT (7'b1100001): present HLT valid for one cycle, PC not incremented, go HALTED.
- HALTED: bubble every cycle, PC frozen, halted=1; leave only by reset; stall and branch ignored.
- Priority: reset > branch_taken > stall > normal advance.
- branch_taken (not HALTED): PC<=branch_target, emit bubble, state<=FETCH; a pending FETCH_IMM is abandoned.
- stall (no branch): every register holds, including outputs and state.
- PC increment wraps modulo 2^PC_W; an IADD at the last address takes its immediate from address 0.

## Timing
- Reset (reset=0 at clk edge): PC=RESET_PC, state FETCH, opcode=NOP, rsrc=rdst=0, imm=0, instr_valid=0, pc_out=RESET_PC, halted=0.
- Latency: word at imem_addr in cycle N appears on opcode after edge N+1; IADD appears one cycle after its immediate word is read (2 fetch cycles, 1 bubble).
- Sustained throughput: one instruction per cycle for one-word instructions.
- Branch asserted in cycle N: imem_addr=branch_target in cycle N+1; instruction there valid after edge N+2.
- Stall released: advance resumes on the next edge with no lost or duplicated word.
- Reset mid-FETCH_IMM or in HALTED: immediate return to reset values; held fields discarded.

## Configuration
- FETCH_HLT_EN defined: HLT detection and HALTED state as above.
- FETCH_HLT_EN undefined: HLT treated as an ordinary one-word instruction (PC increments, fetch continues); HALTED state absent; halted tied to 0.

## Test plan
- Release reset with RESET_PC=0, mem[0..2]=NOT, INC, MOV words -> opcodes 7'b0010001, 7'b0000011, 7'b0010101 on consecutive cycles, pc_out 0,1,2, instr_valid 1.
- mem[4]=IADD rsrc=2 rdst=5, mem[5]=16'h1234 -> one bubble (opcode NOP, valid 0), then opcode 7'b0100000, rsrc 2, rdst 5, imm 16'h1234, pc_out 4; next instruction pc_out 6.
- branch_taken=1, branch_target=16'h0040 in FETCH_IMM with stall=1 -> bubble, imem_addr=16'h0040 next cycle, partial IADD discarded, no valid IADD emitted.
- stall held 3 cycles after ADD presented -> opcode 7'b0001101, pc_out, imem_addr unchanged all 3 cycles; next instruction follows with no skip.
- HLT at mem[8] (FETCH_HLT_EN defined) -> HLT valid once, then halted=1, imem_addr frozen at 8, branch ignored; reset=0 restores PC=RESET_PC, halted=0; with macro undefined, fetch continues to mem[9].
- PC_W=4, IADD at address 15, immediate at 0 -> imm=mem[0], pc_out=15, next fetch from address 1.
